// File: rtl/crypto_loader_pkg.sv
// Shared constants for the crypto_loader register front end: address map,
// STATUS/CTRL bit positions, FSM state codes and block width.
package crypto_loader_pkg;

    localparam int BLOCK_W = 128;

    localparam logic [7:0] ADDR_TEXT_BASE   = 8'h00;
    localparam logic [7:0] ADDR_KEY_BASE    = 8'h10;
    localparam logic [7:0] ADDR_RESULT_BASE = 8'h20;
    localparam logic [7:0] ADDR_CTRL        = 8'h30;
    localparam logic [7:0] ADDR_STATUS      = 8'h31;
    localparam logic [7:0] ADDR_TRIG_LEN    = 8'h32;

    // 16-byte regions are selected by the upper address nibble
    localparam logic [3:0] REG_TEXT   = ADDR_TEXT_BASE[7:4];
    localparam logic [3:0] REG_KEY    = ADDR_KEY_BASE[7:4];
    localparam logic [3:0] REG_RESULT = ADDR_RESULT_BASE[7:4];

    localparam int CTRL_GO  = 0;
    localparam int CTRL_CLR = 1;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_TIMEOUT = 2;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_WAIT_HI = 3'd2;
    localparam logic [2:0] ST_WAIT_LO = 3'd3;
    localparam logic [2:0] ST_CAPTURE = 3'd4;

    function automatic logic [7:0] get_byte(input logic [BLOCK_W-1:0] blk,
                                            input logic [3:0] idx);
        return blk[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/crypto_loader_trig.sv
// Scope trigger: follows the FSM active window, optionally stretched by
// TRIG_LEN cycles when LOADER_TRIG_EXT_EN is defined.
module crypto_loader_trig (
    input  logic       clk,
    input  logic       rst,
    input  logic       active,
    input  logic [7:0] trig_len,
    output logic       trigger,
    output logic       ext_busy
);

`ifdef LOADER_TRIG_EXT_EN
    logic [7:0] ext_cnt_q;

    // Reloaded every active cycle so the count starts at the fall point
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_cnt_q <= 8'd0;
        end else if (active) begin
            ext_cnt_q <= trig_len;
        end else if (ext_cnt_q != 8'd0) begin
            ext_cnt_q <= ext_cnt_q - 8'd1;
        end
    end

    assign ext_busy = (ext_cnt_q != 8'd0);
    assign trigger  = active || ext_busy;
`else
    logic unused_trig;
    assign unused_trig = ^{clk, rst, trig_len};
    assign ext_busy    = 1'b0;
    assign trigger     = active;
`endif

endmodule

// File: rtl/crypto_loader.sv
// Host byte-bus front end for the 128-bit target core: text/key assembly,
// load pulse, busy handshake with timeout, result capture. Macro: LOADER_TRIG_EXT_EN.
module crypto_loader
    import crypto_loader_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 255,
    parameter logic [7:0] TRIG_LEN_RST   = 8'd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         addr_i,
    input  logic               wr_i,
    input  logic               rd_i,
    input  logic [7:0]         wdata_i,
    output logic [7:0]         rdata_o,
    output logic               load_o,
    output logic [BLOCK_W-1:0] text_o,
    output logic [BLOCK_W-1:0] key_o,
    input  logic [BLOCK_W-1:0] core_data_i,
    input  logic               core_busy_i,
    output logic               trigger_o
);

    localparam int TO_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

    logic [2:0]         state_q, state_d;
    logic [BLOCK_W-1:0] text_q, key_q, result_q;
    logic               done_q, timeout_q;
    logic [TO_W-1:0]    to_cnt_q;
    logic [7:0]         rdata_q, rd_mux, status;
    logic [7:0]         trig_len_w;
    logic               ext_busy;

    logic [3:0] region, offs;
    logic       is_idle, ready, cfg_wr, ctrl_wr, go, clr, to_hit, to_fire;

    assign region  = addr_i[7:4];
    assign offs    = addr_i[3:0];
    assign is_idle = (state_q == ST_IDLE);
    // The trigger extension window counts as busy for go and config writes
    assign ready   = is_idle && !ext_busy;
    assign cfg_wr  = wr_i && ready;
    assign ctrl_wr = wr_i && (addr_i == ADDR_CTRL);
    assign go      = ctrl_wr && wdata_i[CTRL_GO] && ready;
    assign clr     = ctrl_wr && wdata_i[CTRL_CLR];
    assign to_hit  = (to_cnt_q == TO_MAX);
    assign to_fire = to_hit && (((state_q == ST_WAIT_HI) && !core_busy_i) ||
                                ((state_q == ST_WAIT_LO) &&  core_busy_i));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (go) state_d = ST_LOAD;
            ST_LOAD:    state_d = ST_WAIT_HI;
            ST_WAIT_HI: begin
                if (core_busy_i)  state_d = ST_WAIT_LO;
                else if (to_hit)  state_d = ST_IDLE;
            end
            ST_WAIT_LO: begin
                if (!core_busy_i) state_d = ST_CAPTURE;
                else if (to_hit)  state_d = ST_IDLE;
            end
            ST_CAPTURE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            text_q    <= '0;
            key_q     <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            to_cnt_q  <= '0;
            rdata_q   <= 8'h00;
        end else begin
            state_q <= state_d;

            if (state_d != state_q) begin
                to_cnt_q <= '0;
            end else if (!to_hit) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end

            if (cfg_wr && (region == REG_TEXT)) text_q[{offs, 3'b000} +: 8] <= wdata_i;
            if (cfg_wr && (region == REG_KEY))  key_q[{offs, 3'b000} +: 8]  <= wdata_i;

            if (clr || go) begin
                done_q    <= 1'b0;
                timeout_q <= 1'b0;
            end
            if (state_q == ST_CAPTURE) begin
                result_q <= core_data_i;
                done_q   <= 1'b1;
            end
            if (to_fire) timeout_q <= 1'b1;

            if (rd_i) rdata_q <= rd_mux;
        end
    end

`ifdef LOADER_TRIG_EXT_EN
    logic [7:0] trig_len_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_len_q <= TRIG_LEN_RST;
        end else if (cfg_wr && (addr_i == ADDR_TRIG_LEN)) begin
            trig_len_q <= wdata_i;
        end
    end

    assign trig_len_w = trig_len_q;
`else
    assign trig_len_w = 8'h00;
`endif

    always_comb begin
        status               = 8'h00;
        status[STAT_BUSY]    = !ready;
        status[STAT_DONE]    = done_q;
        status[STAT_TIMEOUT] = timeout_q;
    end

    always_comb begin
        rd_mux = 8'h00;
        case (region)
            REG_TEXT:   rd_mux = get_byte(text_q, offs);
            REG_KEY:    rd_mux = get_byte(key_q, offs);
            REG_RESULT: rd_mux = get_byte(result_q, offs);
            default: begin
                if (addr_i == ADDR_STATUS) rd_mux = status;
`ifdef LOADER_TRIG_EXT_EN
                if (addr_i == ADDR_TRIG_LEN) rd_mux = trig_len_w;
`endif
            end
        endcase
    end

    crypto_loader_trig u_trig (
        .clk      (clk),
        .rst      (rst),
        .active   (!is_idle),
        .trig_len (trig_len_w),
        .trigger  (trigger_o),
        .ext_busy (ext_busy)
    );

    assign rdata_o = rdata_q;
    assign load_o  = (state_q == ST_LOAD);
    assign text_o  = text_q;
    assign key_o   = key_q;

endmodule

// File: tb/tb_crypto_loader.sv
// Self-checking bench for crypto_loader: table-driven register reads, directed
// timing/corner sequences and randomized transactions against a byte-level model.
module tb_crypto_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   addr_i, wdata_i, rdata_o;
    logic         wr_i, rd_i, load_o, trigger_o, core_busy_i;
    logic [127:0] text_o, key_o, core_data_i;

    crypto_loader #(.TIMEOUT_CYCLES(16), .TRIG_LEN_RST(8'd0)) dut (
        .clk(clk), .rst(rst), .addr_i(addr_i), .wr_i(wr_i), .rd_i(rd_i),
        .wdata_i(wdata_i), .rdata_o(rdata_o), .load_o(load_o), .text_o(text_o),
        .key_o(key_o), .core_data_i(core_data_i), .core_busy_i(core_busy_i),
        .trigger_o(trigger_o)
    );

    always #5 clk = ~clk;

    // Core stand-in: busy for core_len cycles starting core_dly cycles after the load cycle
    logic         core_en = 1'b0;
    int           core_dly = 0, core_len = 1, since;
    logic [127:0] core_out = '0;
    always @(posedge clk or posedge rst) begin
        if (rst)                             since <= 0;
        else if (load_o)                     since <= 1;
        else if (since != 0 && since < 5000) since <= since + 1;
    end
    assign core_busy_i = core_en && (since > core_dly) && (since <= core_dly + core_len);
    assign core_data_i = core_out;

    int load_cnt = 0, trig_cnt = 0;
    always @(negedge clk) begin
        if (load_o)    load_cnt <= load_cnt + 1;
        if (trigger_o) trig_cnt <= trig_cnt + 1;
    end

    // Reference model
    logic [127:0] m_text, m_key, m_result;
    logic         m_busy, m_done, m_to;
    logic [7:0]   m_trig_len;
    int checks = 0, errors = 0;

    typedef struct packed { logic [7:0] addr; logic [7:0] exp; } rd_vec_t;
    rd_vec_t tbl[21];

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%02h required=%02h", nm, act, exp);
        end
    endtask

    task automatic chk128(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%032h required=%032h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_status();
        return {5'd0, m_to, m_done, m_busy};
    endfunction

    task automatic model_reset();
        m_text = '0; m_key = '0; m_result = '0;
        m_busy = 1'b0; m_done = 1'b0; m_to = 1'b0; m_trig_len = 8'd0;
    endtask

    task automatic host_write(input logic [7:0] a, input logic [7:0] d);
        addr_i = a; wdata_i = d; wr_i = 1'b1;
        @(negedge clk);
        wr_i = 1'b0;
        if (!m_busy && a[7:4] == 4'h0) m_text[a[3:0]*8 +: 8] = d;
        if (!m_busy && a[7:4] == 4'h1) m_key[a[3:0]*8 +: 8] = d;
`ifdef LOADER_TRIG_EXT_EN
        if (!m_busy && a == 8'h32) m_trig_len = d;
`endif
        if (a == 8'h30) begin
            if (d[1]) begin m_done = 1'b0; m_to = 1'b0; end
            if (d[0] && !m_busy) begin m_busy = 1'b1; m_done = 1'b0; m_to = 1'b0; end
        end
    endtask

    task automatic host_read(input logic [7:0] a, output logic [7:0] d);
        addr_i = a; rd_i = 1'b1;
        @(negedge clk);
        rd_i = 1'b0;
        d = rdata_o;
    endtask

    task automatic finish_op(input bit exp_done);
        logic [7:0] s;
        s = 8'h01;
        for (int i = 0; i < 300 && s[0]; i++) host_read(8'h31, s);
        chk8("op_completes", {7'd0, s[0]}, 8'h00);
        m_busy = 1'b0;
        if (exp_done) begin m_done = 1'b1; m_result = core_out; end
        else m_to = 1'b1;
        chk8("status_after_op", s, exp_status());
    endtask

    task automatic check_results(input string nm);
        logic [7:0] v;
        for (int i = 0; i < 16; i++) begin
            host_read(8'(32 + i), v);
            chk8(nm, v, m_result[i*8 +: 8]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        int lb, tb0;
        model_reset();
        rst = 1'b1; addr_i = '0; wdata_i = '0; wr_i = 1'b0; rd_i = 1'b0;
        repeat (3) @(negedge clk);
        chk8("rst_load", {7'd0, load_o}, 8'h00);
        chk8("rst_trigger", {7'd0, trigger_o}, 8'h00);
        chk8("rst_rdata", rdata_o, 8'h00);
        chk128("rst_text", text_o, '0);
        chk128("rst_key", key_o, '0);
        rst = 1'b0;
        @(negedge clk);
        host_read(8'h31, v);
        chk8("rst_status", v, 8'h00);

        // Basic transaction with exact cycle timing
        for (int i = 0; i < 16; i++) host_write(8'(i), 8'(i));
        for (int i = 0; i < 16; i++) host_write(8'(16 + i), 8'hAA);
        chk128("text_assembled", text_o, 128'h0f0e0d0c0b0a09080706050403020100);
        chk128("key_assembled", key_o, {16{8'hAA}});
        core_en = 1'b1; core_dly = 0; core_len = 1; core_out = text_o;
        lb = load_cnt; tb0 = trig_cnt;
        host_write(8'h30, 8'h01);
        chk8("load_n1", {7'd0, load_o}, 8'h01);
        chk8("trig_n1", {7'd0, trigger_o}, 8'h01);
        @(negedge clk);
        chk8("load_n2", {7'd0, load_o}, 8'h00);
        repeat (2) @(negedge clk);
        host_read(8'h31, v);
        chk8("status_capture_cycle", v, 8'h01);
        host_read(8'h31, v);
        chk8("status_done_n5", v, 8'h02);
        finish_op(1'b1);
        chk8("single_load", 8'(load_cnt - lb), 8'd1);
        chk8("trig_len_basic", 8'(trig_cnt - tb0), 8'(4 + m_trig_len));

        for (int i = 0; i < 16; i++) tbl[i] = '{addr: 8'(32 + i), exp: 8'(i)};
        tbl[16] = '{addr: 8'h31, exp: 8'h02};
        tbl[17] = '{addr: 8'h40, exp: 8'h00};
        tbl[18] = '{addr: 8'hFF, exp: 8'h00};
        tbl[19] = '{addr: 8'h33, exp: 8'h00};
        tbl[20] = '{addr: 8'h32, exp: 8'h00};
        for (int i = 0; i < 21; i++) begin
            host_read(tbl[i].addr, v);
            chk8($sformatf("tbl_read_%02h", tbl[i].addr), v, tbl[i].exp);
        end

        // Config writes during WAIT_LO are dropped
        core_len = 6;
        host_write(8'h30, 8'h01);
        repeat (3) @(negedge clk);
        host_write(8'h05, 8'hEE);
        host_write(8'h15, 8'h11);
        chk128("text_locked", text_o, m_text);
        chk128("key_locked", key_o, m_key);
        finish_op(1'b1);
        chk128("text_after_op", text_o, m_text);

        // Second go while waiting for busy
        core_dly = 5; core_len = 2;
        lb = load_cnt;
        host_write(8'h30, 8'h01);
        repeat (2) @(negedge clk);
        host_write(8'h30, 8'h01);
        finish_op(1'b1);
        chk8("no_second_load", 8'(load_cnt - lb), 8'd1);
        host_write(8'h30, 8'h02);
        host_read(8'h31, v);
        chk8("clear_flags", v, exp_status());

        // Busy never rises: timeout after 17 WAIT_HI cycles, no capture
        core_en = 1'b0; core_out = {4{$urandom}};
        tb0 = trig_cnt;
        host_write(8'h30, 8'h01);
        repeat (17) @(negedge clk);
        host_read(8'h31, v);
        chk8("status_last_wait_hi", v, 8'h01);
        host_read(8'h31, v);
        chk8("status_timeout", v, 8'h04);
        finish_op(1'b0);
        chk8("trig_len_timeout", 8'(trig_cnt - tb0), 8'(18 + m_trig_len));
        check_results("result_kept_timeout");

        // Busy never falls: timeout from WAIT_LO
        core_en = 1'b1; core_dly = 0; core_len = 1000;
        host_write(8'h30, 8'h01);
        finish_op(1'b0);
        core_en = 1'b0;

        // Randomized transactions
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 32; i++) host_write(8'(i), 8'($urandom));
            host_write(8'($urandom_range(64, 255)), 8'($urandom));
`ifdef LOADER_TRIG_EXT_EN
            host_write(8'h32, 8'($urandom_range(0, 6)));
`endif
            core_en = 1'b1; core_dly = $urandom_range(0, 10); core_len = $urandom_range(1, 8);
            core_out = {$urandom, $urandom, $urandom, $urandom};
            lb = load_cnt; tb0 = trig_cnt;
            host_write(8'h30, 8'h01);
            chk8("rand_load", {7'd0, load_o}, 8'h01);
            finish_op(1'b1);
            chk8("rand_single_load", 8'(load_cnt - lb), 8'd1);
            chk8("rand_trig_len", 8'(trig_cnt - tb0), 8'(core_dly + core_len + 3 + int'(m_trig_len)));
            chk128("rand_text", text_o, m_text);
            chk128("rand_key", key_o, m_key);
            check_results("rand_result");
        end

`ifdef LOADER_TRIG_EXT_EN
        host_write(8'h32, 8'h05);
        host_read(8'h32, v);
        chk8("trig_len_readback", v, 8'h05);
        core_dly = 0; core_len = 1;
        lb = load_cnt; tb0 = trig_cnt;
        host_write(8'h30, 8'h01);
        repeat (4) @(negedge clk);
        chk8("trig_in_ext", {7'd0, trigger_o}, 8'h01);
        host_write(8'h30, 8'h01);
        finish_op(1'b1);
        chk8("ext_go_ignored", 8'(load_cnt - lb), 8'd1);
        chk8("trig_ext_5", 8'(trig_cnt - tb0), 8'd9);
`else
        host_write(8'h32, 8'h5A);
        host_read(8'h32, v);
        chk8("trig_len_absent", v, 8'h00);
`endif

        // Reset in the middle of WAIT_LO
        core_en = 1'b1; core_dly = 0; core_len = 10;
        host_write(8'h30, 8'h01);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk8("midrst_trigger", {7'd0, trigger_o}, 8'h00);
        chk8("midrst_load", {7'd0, load_o}, 8'h00);
        chk8("midrst_rdata", rdata_o, 8'h00);
        chk128("midrst_text", text_o, '0);
        chk128("midrst_key", key_o, '0);
        @(negedge clk);
        rst = 1'b0;
        core_en = 1'b0;
        model_reset();
        host_read(8'h31, v);
        chk8("status_after_rst", v, 8'h00);
        check_results("result_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crypto_loader.md
# crypto_loader

Host-side register front end for the 128-bit target core used in power-analysis captures. Assembles plaintext and key from byte-wide host bus writes, issues a single-cycle load pulse to the downstream 128-bit core, tracks the core's busy handshake, captures the core output into a readable result buffer and drives the scope trigger. Sits directly upstream of the target core, between the host bus bridge and the core.

## Interface
- TIMEOUT_CYCLES, default 255: max cycles waited for each core busy edge before flagging an error.
- TRIG_LEN_RST, default 8'd0: reset value of the trigger-extension register.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- addr_i  in  8  host bus address.
- wr_i  in  1  host write strobe, one cycle per write.
- rd_i  in  1  host read strobe.
- wdata_i  in  8  host write data.
- rdata_o  out  8  host read data, registered; reset 8'h00.
- load_o  out  1  load pulse to core; reset 0.
- text_o  out  128  plaintext to core; reset 0.
- key_o  out  128  key to core; reset 0.
- core_data_i  in  128  core result.
- core_busy_i  in  1  core busy flag.
- trigger_o  out  1  scope trigger; reset 0.

## Operation
- Address map: 0x00–0x0F text bytes, 0x10–0x1F key bytes, 0x20–0x2F result bytes (read-only), 0x30 CTRL (write bit0=go, bit1=clear flags), 0x31 STATUS (read: bit0 busy, bit1 done, bit2 timeout), 0x32 TRIG_LEN (r/w). Byte offset n maps to bits [8n+7:8n]. Unmapped reads return 8'h00; unmapped writes ignored.
- Text/key/TRIG_LEN writes accepted only in IDLE; ignored otherwise. text_o/key_o stable while not IDLE.
- FSM states: IDLE, LOAD, WAIT_HI, WAIT_LO, CAPTURE.
  - IDLE: write of 1 to CTRL bit0 -> LOAD; clears done and timeout.
  - LOAD: load_o=1 for exactly this cycle -> WAIT_HI.
  - WAIT_HI: core_busy_i=1 -> WAIT_LO; timeout counter reaches TIMEOUT_CYCLES -> set timeout, IDLE.
  - WAIT_LO: core_busy_i=0 -> CAPTURE; timeout as above.
  - CAPTURE: result <= core_data_i, done=1 -> IDLE.
- Timeout counter clears on every state change; saturates, no wrap.
- go written while not IDLE: ignored. CTRL bit1 clears done/timeout in any state.
- STATUS busy = (state != IDLE).
- Reset mid-operation: FSM to IDLE, all registers and outputs to reset values, no partial capture.

## Timing
- go write in cycle N -> load_o high in cycle N+1 only.
- Core asserting busy the cycle after load and for one cycle: WAIT_HI N+2, WAIT_LO N+3, CAPTURE N+4, done visible in STATUS read from N+5.
- rdata_o valid the cycle after rd_i; value reflects state at the rd_i cycle.
- trigger_o rises with load_o and falls the cycle after CAPTURE (or after timeout), then extension per Configuration.

## Configuration
- LOADER_TRIG_EXT_EN defined: TRIG_LEN register present; trigger_o held high TRIG_LEN additional cycles after the normal fall point (8-bit down-counter, 0 = no extension). A new go during extension is ignored until extension ends (FSM treated as busy).
- Not defined: TRIG_LEN register and counter absent; address 0x32 reads 8'h00, writes ignored; trigger_o falls at the normal point.

## Structure
- Shared package: address constants (text base, key base, result base, CTRL, STATUS, TRIG_LEN), STATUS bit indices, FSM state enum, 128-bit block width.
- One sub-module natural: crypto_loader_trig, trigger generator with optional extension counter.

## Test plan
- Write text 0x00..0x0F = 0x00..0x0F, key all 0xAA, go; model core (busy one cycle after load, output = text) -> load_o single pulse, result bytes read back 0x00..0x0F, STATUS = 0x02.
- Write to text address 0x05 while in WAIT_LO -> text_o unchanged, write lost.
- Core never asserts busy, TIMEOUT_CYCLES=16 -> STATUS timeout after 17 cycles in WAIT_HI, FSM IDLE, result unchanged.
- Second go during WAIT_HI -> no second load_o pulse.
- rst asserted in WAIT_LO -> all outputs 0 same cycle, STATUS reads 0x00 after release.
- With LOADER_TRIG_EXT_EN, TRIG_LEN=5 -> trigger_o high 5 cycles past capture; without macro, 0x32 reads 0x00.
